axi4_mem_port_arbiter: RTL and testbench
========================================

// Module: axi4_mem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous AXI4 slave memory between the slave's write engine and its read engine.
//  Removes contention when both channel FSMs drive the memory port in the same cycle.
//  Valid/ready-style request/grant per requester; exactly one memory access per cycle.
//  Round-robin with a bounded run length: neither channel starves during long bursts.
//  Returns read data with fixed latency and no buffering.
// PARAMETERS
//  DATA_WIDTH       32    memory word width
//  MEMORY_DEPTH     1024  words in memory; ADDR_WIDTH = $clog2(MEMORY_DEPTH) word-address bits
//  MAX_GRANT_BEATS  4     consecutive grants an owner may take while the other channel waits (>=1)
// PORTS
//  ACLK       in   1           clock, all logic on rising edge
//  ARESETn    in   1           asynchronous active-low reset
//  wr_req     in   1           write engine requests one beat; holds wr_addr/wr_data until granted
//  wr_addr    in   ADDR_WIDTH  write word address
//  wr_data    in   DATA_WIDTH  write data
//  wr_gnt     out  1           combinational; beat accepted at edge where wr_req&wr_gnt
//  rd_req     in   1           read engine requests one beat; holds rd_addr until granted
//  rd_addr    in   ADDR_WIDTH  read word address
//  rd_gnt     out  1           combinational; beat accepted at edge where rd_req&rd_gnt
//  rd_rvalid  out  1           registered; rd_rdata valid this cycle
//  rd_rdata   out  DATA_WIDTH  = mem_rdata (pass-through), meaningful only while rd_rvalid
//  mem_en     out  1           registered memory enable
//  mem_we     out  1           registered write enable
//  mem_addr   out  ADDR_WIDTH  registered word address
//  mem_wdata  out  DATA_WIDTH  registered write data
//  mem_rdata  in   DATA_WIDTH  memory read data, valid the cycle after the memory samples mem_en
// BEHAVIOUR
//  Reset: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_rvalid=0, state=ARB_IDLE, beat_cnt=0, rr_ptr=WR.
//   Reset is immediate: in-flight reads are discarded; no rd_rvalid after reset.
//  States: ARB_IDLE, ARB_WR_OWN, ARB_RD_OWN.
//  prefer_wr = (WR_OWN & beat_cnt<MAX) | (RD_OWN & beat_cnt>=MAX) | (IDLE & rr_ptr==WR).
//  wr_gnt = wr_req & (!rd_req | prefer_wr);  rd_gnt = rd_req & (!wr_req | !prefer_wr).
//   Never both high. A lone requester is always granted in the same cycle: zero-wait, no bubble.
//  Transitions, evaluated per edge:
//   - Grant to current owner: beat_cnt <= sat(beat_cnt+1, MAX).
//   - Grant to the other channel: state <= that owner, beat_cnt <= 1, rr_ptr <= loser.
//   - From IDLE: same as a switch.
//   - No grant: state <= IDLE, beat_cnt <= 0; rr_ptr holds (points away from last owner).
//  Owner drops req while the other waits: the other is granted that cycle; switch costs no cycle.
//  Memory issue, at the accepting edge:
//   mem_en <= wr_gnt|rd_gnt; mem_we <= wr_gnt;
//   mem_addr <= wr_gnt ? wr_addr : rd_addr; mem_wdata <= wr_data when wr_gnt, else hold.
//  Read return: 2-stage flag pipe.
//   rd_pend <= rd_gnt&rd_req; rd_rvalid <= rd_pend.
//   rd_rvalid is high in the 2nd cycle after the accept cycle; throughput 1 beat/cycle.
//   rd_rvalid has no backpressure; the read engine always sinks it.
//  Ordering: accesses reach memory in grant order. Read granted the cycle after a same-address write returns the new data.
//  beat_cnt is $clog2(MAX_GRANT_BEATS+1) bits, saturating. MAX=1 gives strict alternation under contention.
// STRUCTURE
//  Shared package axi4_arb_pkg: typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_WR_OWN, ARB_RD_OWN}.
//   Also typedef enum logic owner_e {OWN_WR, OWN_RD}.
//  Single flat module; grant logic is a small comb block, so no sub-module.
//  axi4 write/read FSMs instantiate this in place of driving mem_* directly.
// TESTING
//  1 Write only: wr_req 3 beats, addr 0x010/0x011/0x012, data A0/A1/A2.
//    -> wr_gnt 3 consecutive cycles.
//    -> mem_en=mem_we=1 with the same addr/data one cycle later each.
//  2 Write 0x0000_0005 @7, then read @7 the next cycle.
//    -> rd_gnt immediately; rd_rvalid 2 cycles after accept; rd_rdata=0x5.
//  3 MAX=4, after reset, wr_req & rd_req held high.
//    -> grant sequence W,W,W,W,R,R,R,R,W,...
//    -> mem_we matches the sequence; rd_rvalid tracks the R beats +2.
//  4 wr owns with beat_cnt=2, wr_req drops while rd_req is high.
//    -> rd_gnt the same cycle; no idle mem_en cycle.
//  5 ARESETn low one cycle after rd_gnt.
//    -> mem_en=0, rd_rvalid stays 0.
//    -> after release, first contention grants wr.
//  6 MAX=1, both requesting 6 cycles.
//    -> W,R,W,R,W,R; never both gnt high (assertion on every cycle).

Source files
------------

// File: rtl/axi4_arb_pkg.sv
// axi4_arb_pkg: arbiter state and owner encodings shared by the memory-port arbiter and its users
package axi4_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_WR_OWN, ARB_RD_OWN} arb_state_e;
    typedef enum logic {OWN_WR, OWN_RD} owner_e;
endpackage

// File: rtl/axi4_mem_port_arbiter.sv
// axi4_mem_port_arbiter: round-robin, run-length-bounded sharing of one sync memory port between write and read engines
//   ACLK/ARESETn             clock, async active-low reset
//   wr_req/wr_addr/wr_data   write beat request, held until wr_gnt (comb)
//   rd_req/rd_addr           read beat request, held until rd_gnt (comb)
//   rd_rvalid/rd_rdata       read return, two cycles after accept; rdata passes mem_rdata through
//   mem_en/we/addr/wdata     registered memory port; mem_rdata valid the cycle after mem_en is sampled
module axi4_mem_port_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int MEMORY_DEPTH    = 1024,
    parameter int MAX_GRANT_BEATS = 4,
    localparam int ADDR_WIDTH     = $clog2(MEMORY_DEPTH),
    localparam int CW             = $clog2(MAX_GRANT_BEATS + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_GRANT_BEATS);

    arb_state_e            state_q, state_d;
    owner_e                rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rd_pend_q, rd_pend_d, rd_rvalid_q, rd_rvalid_d;
    logic                  prefer_wr;

    always_comb begin
        // Owner keeps priority until its run hits MAX; in IDLE the round-robin pointer decides
        prefer_wr   = (state_q == ARB_WR_OWN && beat_cnt_q < MAX_C) ||
                      (state_q == ARB_RD_OWN && beat_cnt_q >= MAX_C) ||
                      (state_q == ARB_IDLE && rr_ptr_q == OWN_WR);
        wr_gnt      = wr_req & (!rd_req | prefer_wr);
        rd_gnt      = rd_req & (!wr_req | !prefer_wr);
        state_d     = wr_gnt ? ARB_WR_OWN : rd_gnt ? ARB_RD_OWN : ARB_IDLE;
        beat_cnt_d  = !(wr_gnt | rd_gnt) ? '0 :
                      state_d != state_q ? CW'(1) :
                      beat_cnt_q == MAX_C ? MAX_C : beat_cnt_q + CW'(1);
        // On a change of owner the pointer aims at the loser; otherwise it holds
        rr_ptr_d    = (wr_gnt && state_q != ARB_WR_OWN) ? OWN_RD :
                      (rd_gnt && state_q != ARB_RD_OWN) ? OWN_WR : rr_ptr_q;
        mem_en_d    = wr_gnt | rd_gnt;
        mem_we_d    = wr_gnt;
        mem_addr_d  = wr_gnt ? wr_addr : rd_addr;
        mem_wdata_d = wr_gnt ? wr_data : mem_wdata_q;
        rd_pend_d   = rd_gnt & rd_req;
        rd_rvalid_d = rd_pend_q;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= OWN_WR;
            beat_cnt_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_rvalid_q <= rd_rvalid_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_rvalid = rd_rvalid_q;
    assign rd_rdata  = mem_rdata;
endmodule

// File: tb/tb_axi4_mem_port_arbiter.sv
// tb_axi4_mem_port_arbiter: scoreboard bench for the memory-port arbiter (MAX=4 instance plus a MAX=1 instance)
module tb_axi4_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt, rd_gnt, rd_rvalid, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] rd_rdata, mem_wdata, mem_rdata;
    logic          wr_gnt1, rd_gnt1, rd_rvalid1, mem_en1, mem_we1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] rd_rdata1, mem_wdata1;
    logic [DW-1:0] mem_rdata1 = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi4_mem_port_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(1024), .MAX_GRANT_BEATS(4)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    axi4_mem_port_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(1024), .MAX_GRANT_BEATS(1)) u_dut1 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt1),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1),
        .rd_rvalid(rd_rvalid1), .rd_rdata(rd_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    // single-port synchronous memory behind the main instance
    logic [DW-1:0] mem [0:1023];
    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // scoreboard: reference memory updated at each write grant, expected read data queued at each read grant
    logic [DW-1:0] ref_mem [bit [AW-1:0]];
    logic [DW-1:0] rdq [$];
    logic [1:0]    rv_sh = '0;
    logic          exp_en = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            check("rst_mem_en", mem_en, 0);
            check("rst_rvalid", rd_rvalid, 0);
            rdq.delete();
            rv_sh  = '0;
            exp_en = 1'b0;
            exp_we = 1'b0;
        end else begin
            check("gnt_excl", wr_gnt & rd_gnt, 0);
            check("gnt_excl1", wr_gnt1 & rd_gnt1, 0);
            check("rvalid_time", rd_rvalid, rv_sh[1]);
            if (rd_rvalid) begin
                if (rdq.size() == 0) check("rvalid_extra", 1, 0);
                else check("rdata", rd_rdata, rdq.pop_front());
            end
            check("mem_en", mem_en, exp_en);
            if (exp_en) begin
                check("mem_we", mem_we, exp_we);
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            rv_sh    = {rv_sh[0], rd_gnt};
            exp_en   = wr_gnt | rd_gnt;
            exp_we   = wr_gnt;
            exp_addr = wr_gnt ? wr_addr : rd_addr;
            if (wr_gnt) begin
                exp_wdata        = wr_data;
                ref_mem[wr_addr] = wr_data;
            end
            if (rd_gnt) rdq.push_back(ref_mem[rd_addr]);
        end
    end

    // drive requests now (just after a rising edge), check grants mid-cycle, return just after the next rising edge
    task automatic step(input logic w, input logic r, input logic ew, input logic er, input string tag);
        wr_req = w;
        rd_req = r;
        @(negedge ACLK);
        check({tag, "_wgnt"}, wr_gnt, ew);
        check({tag, "_rgnt"}, rd_gnt, er);
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rv", rd_rvalid, 0);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pat3;
        @(posedge ACLK);
        #1;
        do_reset();
        // write-only burst
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(10'h010 + i);
            wr_data = 32'hA0 + DW'(i);
            step(1, 0, 1, 0, "t1");
        end
        step(0, 0, 0, 0, "t1_idle");
        // write then read same address
        wr_addr = 10'd7;
        wr_data = 32'h5;
        rd_addr = 10'd7;
        step(1, 0, 1, 0, "t2_w");
        step(0, 1, 0, 1, "t2_r");
        repeat (3) step(0, 0, 0, 0, "t2_idle");
        // owner drops with beat_cnt=2 while reader waits
        wr_addr = 10'h011;
        wr_data = 32'hB1;
        step(1, 0, 1, 0, "t4_w1");
        wr_data = 32'hB2;
        step(1, 1, 1, 0, "t4_w2");
        rd_addr = 10'h011;
        step(0, 1, 0, 1, "t4_r");
        repeat (3) step(0, 0, 0, 0, "t4_idle");
        // sustained contention, MAX=4
        do_reset();
        pat3    = 12'b000011110000;
        wr_addr = 10'h020;
        rd_addr = 10'h020;
        wr_data = 32'hC0;
        for (int i = 11; i >= 0; i--) begin
            step(1, 1, !pat3[i], pat3[i], "t3");
            if (!pat3[i]) wr_data = wr_data + 1;
        end
        repeat (3) step(0, 0, 0, 0, "t3_idle");
        // reset lands right after a read accept
        rd_addr = 10'h010;
        step(0, 1, 0, 1, "t5_r");
        ARESETn = 1'b0;
        rd_req  = 1'b0;
        @(negedge ACLK);
        check("t5_mem_en", mem_en, 0);
        check("t5_rvalid", rd_rvalid, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (3) step(0, 0, 0, 0, "t5_idle");
        step(1, 1, 1, 0, "t5_first");
        step(0, 0, 0, 0, "t5_end");
        // strict alternation on the MAX=1 instance
        do_reset();
        wr_addr = 10'h030;
        rd_addr = 10'h030;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            check("t6_wgnt1", wr_gnt1, (i % 2) == 0);
            check("t6_rgnt1", rd_gnt1, (i % 2) == 1);
            @(posedge ACLK);
            #1;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (4) step(0, 0, 0, 0, "t6_idle");
        check("sb_drain", rdq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
